// File: rtl/uop_issue_queue_pkg.sv
// Shared issue-queue types: physical register and ROB sizing plus the renamed uop record.
package uop_issue_queue_pkg;

  localparam int unsigned NUM_PREGS   = 64;
  localparam int unsigned ROB_ENTRIES = 32;
  localparam int unsigned PREG_W      = $clog2(NUM_PREGS);
  localparam int unsigned ROB_W       = $clog2(ROB_ENTRIES);
  localparam int unsigned PAYLOAD_W   = 16;

  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    preg_t                src1;
    logic                 src1_ready;
    preg_t                src2;
    logic                 src2_ready;
    preg_t                dst;
    logic [ROB_W-1:0]     rob_idx;
    logic [PAYLOAD_W-1:0] payload;
  } iq_uop;

  function automatic logic uop_eligible(iq_uop u);
    return u.src1_ready && u.src2_ready;
  endfunction

endpackage

// File: rtl/iq_select.sv
// Lowest-index priority select: one-hot grant, encoded index and an any-eligible flag.
module iq_select #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         eligible,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any_valid
);

  localparam int unsigned IW = $clog2(N);

  // Scan from the top so the lowest eligible index is the last one written.
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = |eligible;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/uop_issue_queue.sv
// Collapsing age-ordered issue queue: tag wakeup with bypass, oldest-ready select, two-wide insert.
module uop_issue_queue
  import uop_issue_queue_pkg::*;
#(
  parameter int unsigned IQ_ENTRIES = 8,
  parameter int unsigned WB_PORTS   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid_1,
  input  logic                         in_valid_2,
  input  iq_uop                        in_uop_1,
  input  iq_uop                        in_uop_2,
  output logic                         stalled,
  output logic [$clog2(IQ_ENTRIES):0]  num_free,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0]   wb_preg,
  output logic                         out_valid,
  output iq_uop                        out_uop,
  input  logic                         out_ready
);

  localparam int unsigned CW    = $clog2(IQ_ENTRIES) + 1;
  localparam int unsigned IDX_W = $clog2(IQ_ENTRIES);
  localparam int unsigned UOP_W = $bits(iq_uop);

  iq_uop                 ent_q [IQ_ENTRIES];
  iq_uop                 ent_d [IQ_ENTRIES];
  logic [CW-1:0]         free_q, free_d;
  logic [CW-1:0]         occ, occ_kept;
  logic [IQ_ENTRIES-1:0] eligible, grant;
  logic [IDX_W-1:0]      sel_idx;
  logic                  any_eligible, fire, ins_ok;
  logic [1:0]            n_ins;
  logic [UOP_W-1:0]      out_bits;

  function automatic iq_uop wake(iq_uop u, logic [WB_PORTS-1:0] wbv,
                                 logic [WB_PORTS*PREG_W-1:0] wbp);
    iq_uop r;
    r = u;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wbv[k] && wbp[k*PREG_W +: PREG_W] == u.src1) r.src1_ready = 1'b1;
      if (wbv[k] && wbp[k*PREG_W +: PREG_W] == u.src2) r.src2_ready = 1'b1;
    end
    return r;
  endfunction

  // Live entries are always packed into [0, occ).
  assign occ = CW'(IQ_ENTRIES) - free_q;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      eligible[i] = (CW'(i) < occ) && uop_eligible(ent_q[i]);
    end
  end

  iq_select #(
    .N(IQ_ENTRIES)
  ) u_select (
    .eligible (eligible),
    .grant    (grant),
    .idx      (sel_idx),
    .any_valid(any_eligible)
  );

  always_comb begin
    out_bits = '0;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      out_bits = out_bits | (ent_q[i] & {UOP_W{grant[i]}});
    end
    out_uop = iq_uop'(out_bits);
  end

  assign out_valid = any_eligible && !clear;
  assign fire      = out_valid && out_ready;
  assign stalled   = free_q < CW'(2);
  assign num_free  = free_q;
  assign ins_ok    = !stalled && !clear;
  assign n_ins     = ins_ok ? ({1'b0, in_valid_1} + {1'b0, in_valid_2}) : 2'd0;
  assign occ_kept  = occ - CW'(fire);

  // Shift down over the fired slot, then append new uops after the compacted tail.
  always_comb begin
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      int src;
      src = i;
      if (fire && IDX_W'(i) >= sel_idx) src = i + 1;
      if (src < IQ_ENTRIES) ent_d[i] = wake(ent_q[src], wb_valid, wb_preg);
      else                  ent_d[i] = ent_q[i];
      if (ins_ok && CW'(i) == occ_kept && (in_valid_1 || in_valid_2)) begin
        ent_d[i] = wake(in_valid_1 ? in_uop_1 : in_uop_2, wb_valid, wb_preg);
      end
      if (ins_ok && CW'(i) == occ_kept + CW'(1) && in_valid_1 && in_valid_2) begin
        ent_d[i] = wake(in_uop_2, wb_valid, wb_preg);
      end
    end
  end

  assign free_d = clear ? CW'(IQ_ENTRIES) : free_q + CW'(fire) - CW'(n_ins);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) free_q <= CW'(IQ_ENTRIES);
    else        free_q <= free_d;
  end

  // Entry contents need no reset: validity is carried entirely by free_q.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_uop_issue_queue.sv
// Directed bench for uop_issue_queue with an in-order issue scoreboard.
module tb_uop_issue_queue;
  import uop_issue_queue_pkg::*;

  localparam int unsigned NE = 8;
  localparam int unsigned NW = 2;

  logic                  clk = 1'b0;
  logic                  reset, clear, in_valid_1, in_valid_2, out_ready;
  iq_uop                 in_uop_1, in_uop_2, out_uop;
  logic                  stalled, out_valid;
  logic [3:0]            num_free;
  logic [NW-1:0]         wb_valid;
  logic [NW*PREG_W-1:0]  wb_preg;

  int    errors = 0;
  int    checks = 0;
  iq_uop exp_q[$];

  uop_issue_queue #(
    .IQ_ENTRIES(NE),
    .WB_PORTS  (NW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid_1(in_valid_1),
    .in_valid_2(in_valid_2),
    .in_uop_1  (in_uop_1),
    .in_uop_2  (in_uop_2),
    .stalled   (stalled),
    .num_free  (num_free),
    .wb_valid  (wb_valid),
    .wb_preg   (wb_preg),
    .out_valid (out_valid),
    .out_uop   (out_uop),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic iq_uop mk(int rob, int s1, bit r1, int s2, bit r2);
    iq_uop u;
    u.src1       = preg_t'(s1);
    u.src1_ready = r1;
    u.src2       = preg_t'(s2);
    u.src2_ready = r2;
    u.dst        = preg_t'(rob + 1);
    u.rob_idx    = ROB_W'(rob);
    u.payload    = PAYLOAD_W'(rob * 37 + 11);
    return u;
  endfunction

  function automatic iq_uop rdy(iq_uop u);
    iq_uop r;
    r = u;
    r.src1_ready = 1'b1;
    r.src2_ready = 1'b1;
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(bit v1, iq_uop u1, bit v2, iq_uop u2);
    in_valid_1 = v1;
    in_uop_1   = u1;
    in_valid_2 = v2;
    in_uop_2   = u2;
  endtask

  task automatic set_wb(logic [1:0] v, int p0, int p1);
    wb_valid = v;
    wb_preg  = {preg_t'(p1), preg_t'(p0)};
  endtask

  // Settle combinational outputs, then score any fire against the expected issue order.
  task automatic eval();
    iq_uop e;
    #2;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed rob=%0d expected none", out_uop.rob_idx);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_uop", out_uop, e);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    eval();
    adv();
  endtask

  task automatic idle();
    set_in(1'b0, '0, 1'b0, '0);
    set_wb(2'b00, 0, 0);
  endtask

  iq_uop ua, ub, uc, d0, d1, d2, d3, ue, uf, h;
  iq_uop uu[7];
  iq_uop g[5];

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    idle();
    set_in(1'b1, mk(1, 1, 1, 2, 1), 1'b0, '0);

    // Reset held with a valid input present.
    for (int i = 0; i < 3; i++) begin
      adv();
      eval();
      chk("rst_num_free", num_free, 8);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_stalled", stalled, 0);
    end
    reset = 1'b1;
    idle();
    adv();
    eval();
    chk("post_rst_num_free", num_free, 8);
    chk("post_rst_out_valid", out_valid, 0);
    adv();

    // Ordering: A then B.
    out_ready = 1'b1;
    ua = mk(1, 3, 1, 4, 1);
    ub = mk(2, 5, 1, 6, 1);
    exp_q.push_back(ua);
    exp_q.push_back(ub);
    set_in(1'b1, ua, 1'b1, ub);
    eval();
    chk("ord_empty_out_valid", out_valid, 0);
    adv();
    idle();
    eval();
    chk("ord_n1_valid", out_valid, 1);
    chk("ord_n1_rob", out_uop.rob_idx, 1);
    chk("ord_n1_free", num_free, 6);
    adv();
    eval();
    chk("ord_n2_rob", out_uop.rob_idx, 2);
    chk("ord_n2_free", num_free, 7);
    adv();
    eval();
    chk("ord_n3_valid", out_valid, 0);
    chk("ord_n3_free", num_free, 8);
    adv();

    // Wakeup: C waits on p5; a stray broadcast first, duplicate tags later.
    uc = mk(3, 5, 0, 9, 1);
    exp_q.push_back(rdy(uc));
    set_in(1'b1, uc, 1'b0, '0);
    cyc();
    idle();
    set_wb(2'b01, 33, 0);
    eval();
    chk("wk_n1_valid", out_valid, 0);
    adv();
    idle();
    eval();
    chk("wk_n2_valid", out_valid, 0);
    adv();
    set_wb(2'b11, 5, 5);
    eval();
    chk("wk_n3_valid", out_valid, 0);
    adv();
    idle();
    eval();
    chk("wk_n4_valid", out_valid, 1);
    chk("wk_n4_rob", out_uop.rob_idx, 3);
    adv();

    // Bypass and age: D2 first, then woken D0 ahead of D3, E via bypass, then D1.
    d0 = mk(10, 20, 0, 1, 1);
    d1 = mk(11, 21, 0, 1, 1);
    d2 = mk(12, 1, 1, 2, 1);
    d3 = mk(13, 3, 1, 4, 1);
    ue = mk(14, 8, 1, 7, 0);
    exp_q.push_back(d2);
    exp_q.push_back(rdy(d0));
    exp_q.push_back(d3);
    exp_q.push_back(rdy(ue));
    exp_q.push_back(rdy(d1));
    set_in(1'b1, d0, 1'b1, d1);
    cyc();
    set_in(1'b1, d2, 1'b1, d3);
    eval();
    chk("age_blocked_valid", out_valid, 0);
    adv();
    idle();
    set_wb(2'b01, 20, 0);
    cyc();
    idle();
    eval();
    chk("age_d0_rob", out_uop.rob_idx, 10);
    adv();
    set_in(1'b1, ue, 1'b0, '0);
    set_wb(2'b10, 0, 7);
    cyc();
    idle();
    set_wb(2'b01, 21, 0);
    eval();
    chk("byp_e_rob", out_uop.rob_idx, 14);
    adv();
    idle();
    cyc();
    eval();
    chk("age_drain_valid", out_valid, 0);
    chk("age_drain_free", num_free, 8);
    adv();

    // Full: seven non-ready uops, dropped insert, then one dispatch frees room.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) uu[i] = mk(20 + i, 40 + i, 0, 1, 1);
    set_in(1'b1, uu[0], 1'b1, uu[1]);
    cyc();
    set_in(1'b1, uu[2], 1'b1, uu[3]);
    cyc();
    set_in(1'b1, uu[4], 1'b1, uu[5]);
    cyc();
    set_in(1'b1, uu[6], 1'b0, '0);
    eval();
    chk("full_pre_stalled", stalled, 0);
    chk("full_pre_free", num_free, 2);
    adv();
    uf = mk(30, 1, 1, 2, 1);
    set_in(1'b1, uf, 1'b0, '0);
    eval();
    chk("full_stalled", stalled, 1);
    chk("full_free", num_free, 1);
    adv();
    idle();
    set_wb(2'b01, 43, 0);
    eval();
    chk("full_drop_free", num_free, 1);
    chk("full_drop_valid", out_valid, 0);
    adv();
    idle();
    out_ready = 1'b1;
    exp_q.push_back(rdy(uu[3]));
    eval();
    chk("full_fire_valid", out_valid, 1);
    chk("full_fire_stalled", stalled, 1);
    adv();
    out_ready = 1'b0;
    eval();
    chk("full_after_free", num_free, 2);
    chk("full_after_stalled", stalled, 0);
    adv();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    eval();
    chk("flush_free", num_free, 8);
    adv();

    // Clear: five entries, one presentable, concurrent insert ignored.
    g[0] = mk(50, 1, 1, 2, 1);
    for (int i = 1; i < 5; i++) g[i] = mk(50 + i, 10 + i, 0, 1, 1);
    set_in(1'b1, g[0], 1'b1, g[1]);
    cyc();
    set_in(1'b1, g[2], 1'b1, g[3]);
    cyc();
    set_in(1'b1, g[4], 1'b0, '0);
    cyc();
    idle();
    eval();
    chk("clr_pre_valid", out_valid, 1);
    chk("clr_pre_free", num_free, 3);
    adv();
    h = mk(60, 1, 1, 2, 1);
    set_in(1'b1, h, 1'b0, '0);
    clear = 1'b1;
    out_ready = 1'b1;
    eval();
    chk("clr_out_valid", out_valid, 0);
    adv();
    clear = 1'b0;
    idle();
    eval();
    chk("clr_after_free", num_free, 8);
    chk("clr_after_valid", out_valid, 0);
    adv();

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uop_issue_queue.md
# uop_issue_queue

Out-of-order issue queue sitting directly downstream of the microcode issue stage. It accepts up to two renamed uops per cycle and holds them until both physical source registers are ready. Ready state is learned from writeback tag broadcasts. Each cycle it dispatches the oldest ready uop to one execution port. Entries are kept in a collapsing, age-ordered array: index 0 is always the oldest.

## Interface
Parameters:
- IQ_ENTRIES, 8: queue depth (≥4, power of two not required)
- WB_PORTS, 2: number of writeback wakeup broadcasts per cycle

Ports (preg width = $clog2(NUM_PREGS)):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- clear  in  1  synchronous flush of all entries
- in_valid_1 / in_valid_2  in  1  slot valid; slot 1 is older than slot 2
- in_uop_1 / in_uop_2  in  iq_uop  src1, src1_ready, src2, src2_ready, dst, rob_idx, payload
- stalled  out  1  upstream must hold; registered-state derived
- num_free  out  $clog2(IQ_ENTRIES)+1  free entry count
- wb_valid  in  WB_PORTS  wakeup broadcast valid per port
- wb_preg  in  WB_PORTS×preg  broadcast physical register tags
- out_valid  out  1  a ready uop is presented
- out_uop  out  iq_uop  oldest ready entry
- out_ready  in  1  execution port accepts; fire = out_valid && out_ready

## Operation
- stalled = (num_free < 2), computed from registered count only. Same-cycle dispatch is not credited, so the check is conservative.
- Insertion happens when !stalled && !clear. Valid slots are appended at the tail in order (slot 1, then slot 2). in_valid_2 without in_valid_1 occupies one entry.
- Wakeup: at each edge, for every valid entry and each source with wb_valid[k] && wb_preg[k]==src, set that source's ready bit.
- Bypass: incoming uops are compared against the same-cycle broadcasts. A match is written ready.
- Eligible means valid && src1_ready && src2_ready.
- Select picks the lowest-index eligible entry combinationally from registered state. If any entry is eligible, out_valid=1 and out_uop is that entry.
- On fire, the selected entry is removed at the edge. Entries above it shift down one, then new uops append after the compacted tail.
- num_free is updated as num_free + fire − inserted.
- clear:
  - All entries are invalidated at the edge.
  - Inputs are ignored that cycle.
  - out_valid is forced 0 while clear=1.
  - num_free becomes IQ_ENTRIES.
- Async reset:
  - All entries are invalidated immediately.
  - out_valid=0, stalled=0, num_free=IQ_ENTRIES.
  - The payload contents are don't-care.

## Timing
- Insert at edge N; the uop is earliest visible on out_valid in cycle N+1 (1-cycle issue latency).
- A wakeup broadcast in cycle M makes the entry eligible from cycle M+1. This also holds for a uop inserted in cycle M via bypass.
- Fire in cycle M removes the entry at edge M+1. The next-oldest eligible entry is presented in cycle M+1.
- A broadcast for a preg nobody waits on has no effect.
- Duplicate tags on two wb ports are legal and idempotent.
- Full queue: stalled stays asserted until num_free ≥ 2 after a dispatch. Inputs presented while stalled are dropped, not buffered.
- Reset released mid-cycle: the first legal insertion is the first edge with reset=1.

## Structure
- Shared package (with defines.inc): the iq_uop typedef (preg fields, ready bits, rob_idx sized $clog2(ROB_ENTRIES), payload). NUM_PREGS and ROB_ENTRIES come from there, not local parameters.
- One sub-module, iq_select: IQ_ENTRIES-wide eligibility vector → one-hot lowest-index grant plus encoded index plus any_valid.
- Everything else lives in uop_issue_queue: entry array, wakeup comparators, compaction, counters.

## Test plan
- Reset: hold reset=0 for 3 cycles with in_valid_1=1, then release. Expect num_free=8, out_valid=0, stalled=0, and no entry inserted during reset.
- Ordering: insert A,B (both ready) with out_ready=1. Expect out_uop=A in cycle N+1 and B in N+2, then out_valid=0 and num_free=8.
- Wakeup: insert C with src1=p5 not ready, then broadcast wb_preg=5 in cycle N+3. Expect out_valid=0 through N+3 and out_uop=C in N+4.
- Bypass and age: entries idx0..3, where only idx2 and idx3 are ready, with out_ready=1. Expect idx2 issued, then wake idx0. Expect idx0 issued before idx3. A uop inserted with src2=p7 in the same cycle as broadcast p7 issues the next cycle.
- Full: insert 7 non-ready uops. Expect stalled=1 with num_free=1, and a further insert is dropped. Broadcast to make one entry ready and fire it. Expect num_free=2 and stalled=0 the cycle after.
- Clear: with 5 entries, one out_valid, and out_ready=1, pulse clear. Expect out_valid=0 that cycle, no fire, and num_free=8 next cycle. The concurrent insert is ignored.
